// File: rtl/trigger_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture_pkg
// Description : Shared constants for the trigger capture block: FSM state
//               encoding and trigger edge codes.
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_capture_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] S_PRETRIG   = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT_TRIG = 3'd2;
    localparam logic [STATE_W-1:0] S_POSTTRIG  = 3'd3;
    localparam logic [STATE_W-1:0] S_READOUT   = 3'd4;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

endpackage
`default_nettype wire

// File: rtl/trigger_capture_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture_sample_ram
// Description : Simple dual-port sample RAM, one write port and one
//               synchronous read port (1-cycle latency), single clock.
// Ports       : clk_i   - clock
//               i_wr_en - write enable
//               i_waddr - write address
//               i_wdata - write data
//               i_raddr - read address
//               o_rdata - read data, valid the cycle after i_raddr
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture_sample_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [DATA_WIDTH-1:0] r_rdata;

    // No reset on the array or the read register so this maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (i_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture
// Description : Pretrigger/posttrigger acquisition stage. Stores ADC samples
//               in a circular RAM, detects a level/edge or forced trigger,
//               then replays the frame oldest-first over a rdy/ack port.
// Ports       : clk_i, rst (sync, active-high)
//               in_data/in_rdy/in_ack        - ADC sample input
//               start, force_trig            - arm / force trigger
//               trig_level, trig_falling     - trigger condition
//               pretrig, num_samples         - frame geometry
//               out_data/out_rdy/out_ack     - readout port
//               busy, triggered, done        - status
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_rdy,
    output logic                  in_ack,
    input  logic                  start,
    input  logic                  force_trig,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_falling,
    input  logic [ADDR_WIDTH:0]   pretrig,
    input  logic [ADDR_WIDTH:0]   num_samples,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_rdy,
    input  logic                  out_ack,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    localparam int c_cnt_w = ADDR_WIDTH + 1;
    localparam logic [c_cnt_w-1:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [STATE_W-1:0]    r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_start_addr;
    logic [c_cnt_w-1:0]    r_pre_cnt;
    logic [c_cnt_w-1:0]    r_post_cnt;
    logic [c_cnt_w-1:0]    r_rd_cnt;
    logic [c_cnt_w-1:0]    r_pretrig;
    logic [c_cnt_w-1:0]    r_num;
    logic [DATA_WIDTH-1:0] r_level;
    logic                  r_falling;
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_valid;
    logic                  r_force_pend;
    logic                  r_rd_pipe;
    logic                  r_triggered;
    logic                  r_done;
    logic                  r_out_rdy;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_capturing;
    logic                  w_accept;
    logic [c_cnt_w-1:0]    w_num_clamped;
    logic [c_cnt_w-1:0]    w_pre_clamped;
    logic                  w_level_hit;
    logic                  w_trig;
    logic [c_cnt_w-1:0]    w_post_len;
    logic [ADDR_WIDTH-1:0] w_trig_start;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_capturing = (r_state == S_PRETRIG) || (r_state == S_WAIT_TRIG) ||
                         (r_state == S_POSTTRIG);
    assign w_accept    = w_capturing && in_rdy;

    // Frame geometry is clamped once at arm time so every counter below
    // stays within c_cnt_w bits for the whole frame.
    assign w_num_clamped = ((num_samples == '0) || (num_samples > c_depth)) ?
                           c_depth : num_samples;
    assign w_pre_clamped = (pretrig >= w_num_clamped) ? (w_num_clamped - c_one) : pretrig;

    assign w_level_hit = r_prev_valid &&
                         ((r_falling == EDGE_FALLING) ?
                          ((r_prev >= r_level) && (in_data <  r_level)) :
                          ((r_prev <  r_level) && (in_data >= r_level)));

    // A force request seen without a sample is remembered until the next
    // accepted sample, which then becomes the trigger sample.
    assign w_trig = w_accept && (r_state == S_WAIT_TRIG) &&
                    (force_trig || r_force_pend || w_level_hit);

    assign w_post_len   = r_num - r_pretrig;
    assign w_trig_start = r_wr_ptr - r_pretrig[ADDR_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_addr    <= '0;
            r_start_addr <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_rd_cnt     <= '0;
            r_pretrig    <= '0;
            r_num        <= '0;
            r_level      <= '0;
            r_falling    <= 1'b0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_force_pend <= 1'b0;
            r_rd_pipe    <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_out_rdy    <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_prev       <= in_data;
                r_prev_valid <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_level      <= trig_level;
                        r_falling    <= trig_falling;
                        r_num        <= w_num_clamped;
                        r_pretrig    <= w_pre_clamped;
                        r_prev_valid <= 1'b0;
                        r_force_pend <= 1'b0;
                        r_pre_cnt    <= '0;
                        r_post_cnt   <= '0;
                        r_triggered  <= 1'b0;
                        r_state      <= (w_pre_clamped == '0) ? S_WAIT_TRIG : S_PRETRIG;
                    end
                end

                S_PRETRIG: begin
                    if (w_accept) begin
                        r_pre_cnt <= r_pre_cnt + 1'b1;
                        if ((r_pre_cnt + 1'b1) == r_pretrig) begin
                            r_state <= S_WAIT_TRIG;
                        end
                    end
                end

                S_WAIT_TRIG: begin
                    if (w_trig) begin
                        r_start_addr <= w_trig_start;
                        r_triggered  <= 1'b1;
                        r_force_pend <= 1'b0;
                        r_post_cnt   <= c_one;
                        if (w_post_len == c_one) begin
                            r_state   <= S_READOUT;
                            r_rd_addr <= w_trig_start;
                            r_rd_cnt  <= '0;
                            r_rd_pipe <= 1'b0;
                        end else begin
                            r_state <= S_POSTTRIG;
                        end
                    end else if (force_trig) begin
                        r_force_pend <= 1'b1;
                    end
                end

                S_POSTTRIG: begin
                    if (w_accept) begin
                        r_post_cnt <= r_post_cnt + 1'b1;
                        if ((r_post_cnt + 1'b1) == w_post_len) begin
                            r_state   <= S_READOUT;
                            r_rd_addr <= r_start_addr;
                            r_rd_cnt  <= '0;
                            r_rd_pipe <= 1'b0;
                        end
                    end
                end

                S_READOUT: begin
                    // Each word takes one cycle to present the address to the
                    // RAM and one more to register its output onto out_data.
                    if (r_out_rdy) begin
                        if (out_ack) begin
                            r_out_rdy <= 1'b0;
                            r_rd_addr <= r_rd_addr + 1'b1;
                            r_rd_cnt  <= r_rd_cnt + 1'b1;
                            if ((r_rd_cnt + 1'b1) == r_num) begin
                                r_state     <= S_IDLE;
                                r_done      <= 1'b1;
                                r_triggered <= 1'b0;
                            end
                        end
                    end else if (!r_rd_pipe) begin
                        r_rd_pipe <= 1'b1;
                    end else begin
                        r_rd_pipe  <= 1'b0;
                        r_out_rdy  <= 1'b1;
                        r_out_data <= w_ram_rdata;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    trigger_capture_sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sample_ram (
        .clk_i   (clk_i),
        .i_wr_en (w_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_addr),
        .o_rdata (w_ram_rdata)
    );

    assign in_ack    = w_accept;
    assign out_data  = r_out_data;
    assign out_rdy   = r_out_rdy;
    assign busy      = (r_state != S_IDLE);
    assign triggered = r_triggered;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_capture
// Description : Directed self-checking bench for trigger_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

    logic       clk_i = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_rdy = 1'b0;
    logic       in_ack;
    logic       start = 1'b0;
    logic       force_trig = 1'b0;
    logic [7:0] trig_level = '0;
    logic       trig_falling = 1'b0;
    logic [9:0] pretrig = '0;
    logic [9:0] num_samples = '0;
    logic [7:0] out_data;
    logic       out_rdy;
    logic       out_ack = 1'b0;
    logic       busy;
    logic       triggered;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];

    trigger_capture #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (9)
    ) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .in_data      (in_data),
        .in_rdy       (in_rdy),
        .in_ack       (in_ack),
        .start        (start),
        .force_trig   (force_trig),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .pretrig      (pretrig),
        .num_samples  (num_samples),
        .out_data     (out_data),
        .out_rdy      (out_rdy),
        .out_ack      (out_ack),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        in_data = d;
        in_rdy  = 1'b1;
        tick();
        in_rdy  = 1'b0;
    endtask

    task automatic arm(input logic [7:0] lvl, input logic fall,
                       input logic [9:0] pre, input logic [9:0] num);
        trig_level   = lvl;
        trig_falling = fall;
        pretrig      = pre;
        num_samples  = num;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    // Reads one word: checks the 2-cycle presentation latency, the data,
    // optionally holds off the ack to check stability, then acks.
    task automatic read_word(input logic [7:0] exp, input int hold, input string tag);
        int n = 0;
        while (!out_rdy && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        chk({tag, "_data"}, out_data, exp);
        if (hold > 0) begin
            repeat (hold) tick();
            chk({tag, "_hold_rdy"}, out_rdy, 1);
            chk({tag, "_hold_data"}, out_data, exp);
        end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    task automatic read_frame(input int hold_first, input string tag);
        int n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            read_word(exp_q[i], (i == 0) ? hold_first : 0, tag);
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_trig_clr"}, triggered, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        in_rdy = 1'b1;
        #1;
        chk("rst_in_ack", in_ack, 0);
        in_rdy = 1'b0;
        chk("rst_out_rdy", out_rdy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Ramp, rising at 100, pretrig 4, 10 samples -> 96..105
        arm(8'd100, 1'b0, 10'd4, 10'd10);
        for (int k = 0; k < 100; k++) feed(8'(k));
        chk("ramp_not_trig", triggered, 0);
        feed(8'd100);
        chk("ramp_trig", triggered, 1);
        for (int k = 101; k <= 105; k++) feed(8'(k));
        for (int k = 96; k <= 105; k++) exp_q.push_back(8'(k));
        read_frame(5, "ramp");

        // Falling at 50, pretrig 1, 3 samples -> 55,49,40
        arm(8'd50, 1'b1, 10'd1, 10'd3);
        feed(8'd60);
        feed(8'd55);
        chk("fall_not_trig", triggered, 0);
        feed(8'd49);
        chk("fall_trig", triggered, 1);
        feed(8'd40);
        exp_q.push_back(8'd55);
        exp_q.push_back(8'd49);
        exp_q.push_back(8'd40);
        read_frame(0, "fall");

        // Constant 20, forced trigger, pretrig 0, 1 sample; leaves wr_ptr at 510
        arm(8'd10, 1'b0, 10'd0, 10'd1);
        for (int k = 0; k < 399; k++) feed(8'd20);
        chk("force_not_trig", triggered, 0);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        chk("force_pending_busy", busy, 1);
        feed(8'd20);
        chk("force_trig", triggered, 1);
        in_rdy = 1'b1;
        #1;
        chk("readout_in_ack", in_ack, 0);
        in_rdy = 1'b0;
        exp_q.push_back(8'd20);
        read_frame(0, "force");

        // num_samples 0, pretrig 600 -> 512 / 511, wrapping frame from addr 510
        arm(8'd0, 1'b0, 10'd600, 10'd0);
        for (int k = 0; k < 511; k++) feed(8'(k));
        chk("clamp_busy", busy, 1);
        force_trig = 1'b1;
        feed(8'd255);
        force_trig = 1'b0;
        chk("clamp_trig", triggered, 1);
        for (int k = 0; k < 511; k++) exp_q.push_back(8'(k));
        exp_q.push_back(8'd255);
        read_frame(0, "clamp");

        // Reset during POSTTRIG, then a fresh capture
        arm(8'd100, 1'b0, 10'd2, 10'd8);
        for (int k = 0; k <= 101; k++) feed(8'(k));
        chk("post_trig", triggered, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_rdy", out_rdy, 0);
        chk("midrst_trig", triggered, 0);
        arm(8'd30, 1'b0, 10'd3, 10'd5);
        for (int k = 0; k <= 31; k++) feed(8'(k));
        for (int k = 27; k <= 31; k++) exp_q.push_back(8'(k));
        read_frame(0, "rearm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trigger_capture.md
# trigger_capture

Acquisition stage directly downstream of the ADC interface. Consumes ADC samples over the simple interface (data/rdy/ack), keeps a configurable pretrigger history in a circular sample RAM, and detects a level/edge trigger or a forced trigger. Captures the post-trigger samples, then replays the whole frame in chronological order over a second simple interface towards the host transfer logic.

## Interface
- DATA_WIDTH, 8, sample width; matches the ADC interface data width.
- ADDR_WIDTH, 9, RAM address width; DEPTH = 2^ADDR_WIDTH = 512 samples.
- clk_i  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  DATA_WIDTH  sample from ADC interface (SI_data).
- in_rdy  in  1  sample valid (SI_rdy).
- in_ack  out  1  sample accepted (to SI_ack); combinational.
- start  in  1  one-cycle arm request; honoured only in IDLE.
- force_trig  in  1  trigger immediately; honoured only in WAIT_TRIG.
- trig_level  in  DATA_WIDTH  unsigned trigger threshold.
- trig_falling  in  1  0 = rising edge, 1 = falling edge.
- pretrig  in  ADDR_WIDTH+1  samples stored before the trigger sample.
- num_samples  in  ADDR_WIDTH+1  total frame length, including the trigger sample.
- out_data  out  DATA_WIDTH  readout sample.
- out_rdy  out  1  readout sample valid.
- out_ack  in  1  readout sample consumed.
- busy  out  1  high in every state except IDLE.
- triggered  out  1  high from trigger detection until the frame returns to IDLE.
- done  out  1  one-cycle pulse after the last readout ack.

## Operation
- States: IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, READOUT.
- Accept: in_ack = in_rdy while in PRETRIG, WAIT_TRIG or POSTTRIG; otherwise 0. In those states, an unacked ADC sample is dropped by the ADC interface.
- Config latch: trig_level, trig_falling, pretrig and num_samples are registered on an accepted start and held until IDLE.
- Clamping at latch time:
  - num_samples of 0 or greater than DEPTH becomes DEPTH.
  - pretrig of num_samples or more becomes num_samples-1.
- Writes: every accepted sample is written at wr_ptr, then wr_ptr increments modulo DEPTH. wr_ptr resets to 0 and is not cleared between frames.
- IDLE, on start:
  - pretrig = 0 goes to WAIT_TRIG.
  - Otherwise goes to PRETRIG with pre_cnt = 0.
- PRETRIG: pre_cnt increments per accepted sample. After the pretrig-th sample, go to WAIT_TRIG.
- WAIT_TRIG: samples are written continuously, overwriting the oldest history.
  - prev holds the last accepted sample; prev_valid is cleared on start.
  - Rising trigger: prev_valid && prev < trig_level && cur >= trig_level.
  - Falling trigger: prev_valid && prev >= trig_level && cur < trig_level.
  - force_trig triggers on the next accepted sample, regardless of level.
  - On trigger:
    - The current sample is written and is post-sample #1.
    - Latch start_addr = (trigger address − pretrig) mod DEPTH.
    - Set triggered.
    - If num_samples − pretrig = 1, go straight to READOUT; otherwise go to POSTTRIG.
- POSTTRIG: post_cnt counts accepted samples. When num_samples − pretrig samples (trigger sample included) are written, go to READOUT.
- READOUT: num_samples words are read from start_addr upward, modulo DEPTH.
  - Read address advances only on out_rdy && out_ack.
  - After the last ack, go to IDLE and pulse done.
- Comparisons are unsigned. All counters are ADDR_WIDTH+1 bits; no counter overflows after clamping.

## Timing
- Reset values: in_ack 0, out_rdy 0, out_data 0, busy 0, triggered 0, done 0; state IDLE; wr_ptr, pre_cnt, post_cnt 0; prev_valid 0.
- RAM read is synchronous, 1-cycle latency.
- out_rdy first rises 2 cycles after the READOUT entry edge.
- After each ack, the next out_rdy/out_data comes 2 cycles later, with out_rdy low in between.
- out_data is stable while out_rdy is high and out_ack is low.
- Write and trigger evaluation occur in the cycle in_rdy && in_ack. The state change is visible the next cycle.
- start and force_trig in the same cycle as a state-change edge: start counts only if state is IDLE in that cycle; force_trig counts only if state is WAIT_TRIG in that cycle.
- rst mid-frame: state returns to IDLE next edge and out_rdy drops. RAM contents are don't-care.

## Structure
- Shared package holds:
  - state encoding localparams (S_IDLE … S_READOUT);
  - edge codes (EDGE_RISING = 0, EDGE_FALLING = 1).
- Sub-module sample_ram: simple dual-port RAM, DATA_WIDTH × 2^ADDR_WIDTH. One write port, one synchronous read port, same clk_i. Written to infer block RAM.
- Top holds the FSM, counters, trigger comparator and readout handshake.

## Test plan
- Ramp input 0,1,2…; rising, level 100, pretrig 4, num_samples 10 -> readout 96..105; done after the 10th ack.
- Falling, level 50, input 60,55,49,…; pretrig 1, num_samples 3 -> readout 55,49,next; triggered rises on the 49 write.
- Constant input 20 with force_trig in WAIT_TRIG; pretrig 0, num_samples 1 -> one word 20; in_ack low during READOUT.
- num_samples 0, pretrig 600, with wr_ptr near 510 -> clamped to 512/511; readout wraps the address and is in order.
- out_ack held low 5 cycles -> out_data stable; each following word appears 2 cycles after its ack.
- rst asserted during POSTTRIG -> next cycle busy 0, out_rdy 0; a new start performs a correct capture.
